// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU command sequencer.
//   op_e    : decoded command class (funct3 0..3, everything else illegal)
//   bus_e   : datapath bus source select codes
//   state_e : sequencer FSM states
package cfu_pkg;

   typedef enum logic [2:0] {
      OP_CSR = 3'd0,
      OP_ALU = 3'd1,
      OP_MUL = 3'd2,
      OP_ACC = 3'd3,
      OP_ILL = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      BUS_NONE = 2'b00,
      BUS_ALU  = 2'b01,
      BUS_MUL  = 2'b10,
      BUS_ACC  = 2'b11
   } bus_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      RESP = 2'd3
   } state_e;

   function automatic op_e decode_op(input logic [2:0] funct3);
      op_e op;
      case (funct3)
         3'd0:    op = OP_CSR;
         3'd1:    op = OP_ALU;
         3'd2:    op = OP_MUL;
         3'd3:    op = OP_ACC;
         default: op = OP_ILL;
      endcase
      return op;
   endfunction

   function automatic bus_e op_to_bus(input op_e op);
      bus_e b;
      case (op)
         OP_ALU:  b = BUS_ALU;
         OP_MUL:  b = BUS_MUL;
         OP_ACC:  b = BUS_ACC;
         default: b = BUS_NONE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cfu_cmd_sequencer.sv
// CFU command sequencer: accepts one CFU command at a time, decodes it and
// sequences the datapath (bus select, ALU controls, register-file writeback)
// before returning a single response.
//   clk, reset                 : clock, asynchronous active-low reset
//   cmd_*                      : command handshake + function_id/operands
//   rsp_*                      : response handshake + 32-bit payload
//   reg_op0/op1/wb_sel,reg_load: register-file selects and writeback strobe
//   bus_sel, alu_*             : datapath controls held during EXEC/WB
//   vtype, vlen, vlmul         : vector CSR state written by CSR commands
//   acc_out                    : accumulator value returned by ACC commands
//   busy                       : high whenever the FSM is not IDLE
module cfu_cmd_sequencer
   import cfu_pkg::*;
#(
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned VLEN_MAX = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0,
   output logic [4:0]  reg_op0_sel,
   output logic [4:0]  reg_op1_sel,
   output logic [4:0]  reg_wb_sel,
   output logic        reg_load,
   output logic [1:0]  bus_sel,
   output logic [1:0]  alu_mode,
   output logic        alu_op1_sel,
   output logic [7:0]  alu_imm,
   output logic [31:0] vtype,
   output logic [5:0]  vlen,
   output logic [2:0]  vlmul,
   input  logic [7:0]  acc_out,
   output logic        busy
);

   state_e     state, state_nxt;
   op_e        cmd_op, op_q;
   bus_e       bus_c;
   logic [3:0] cnt;
   logic [6:0] funct7;
   logic [5:0] vlen_new;
   logic       accept;
   logic       unused_funct7_hi;

   assign funct7           = cmd_payload_function_id[9:3];
   assign cmd_op           = decode_op(cmd_payload_function_id[2:0]);
   assign accept           = cmd_valid & cmd_ready;
   assign unused_funct7_hi = ^funct7[6:3];

   // Any value above VLEN_MAX (including all-ones) clamps to VLEN_MAX.
   assign vlen_new = (cmd_payload_inputs_1 > 32'(VLEN_MAX)) ? 6'(VLEN_MAX)
                                                           : cmd_payload_inputs_1[5:0];

   assign vlmul   = vtype[2:0];
   assign busy    = (state != IDLE);
   assign bus_sel = bus_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      reg_load  = 1'b0;
      bus_c     = BUS_NONE;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_op == OP_CSR || cmd_op == OP_ILL) state_nxt = RESP;
               else                                      state_nxt = EXEC;
            end
         end
         EXEC: begin
            bus_c = op_to_bus(op_q);
            if (cnt == 4'd1) state_nxt = WB;
         end
         WB: begin
            bus_c     = op_to_bus(op_q);
            reg_load  = (op_q != OP_ACC);
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q                  <= OP_CSR;
         cnt                   <= '0;
         vtype                 <= '0;
         vlen                  <= '0;
         rsp_payload_outputs_0 <= '0;
         reg_op0_sel           <= '0;
         reg_op1_sel           <= '0;
         reg_wb_sel            <= '0;
         alu_mode              <= '0;
         alu_op1_sel           <= 1'b0;
         alu_imm               <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q <= cmd_op;
                  // Illegal commands leave every select/CSR untouched.
                  if (cmd_op != OP_ILL) begin
                     reg_op0_sel <= cmd_payload_inputs_0[4:0];
                     reg_op1_sel <= cmd_payload_inputs_0[12:8];
                     reg_wb_sel  <= cmd_payload_inputs_0[20:16];
                     alu_mode    <= funct7[1:0];
                     alu_op1_sel <= funct7[2];
                     alu_imm     <= cmd_payload_inputs_1[7:0];
                  end
                  case (cmd_op)
                     OP_CSR: begin
                        vtype                 <= cmd_payload_inputs_0;
                        vlen                  <= vlen_new;
                        rsp_payload_outputs_0 <= {26'b0, vlen_new};
                     end
                     OP_ILL:  rsp_payload_outputs_0 <= '1;
                     OP_MUL:  cnt <= 4'(MUL_LAT);
                     default: cnt <= 4'd1;
                  endcase
               end
            end
            EXEC: cnt <= cnt - 4'd1;
            WB: begin
               if (op_q == OP_ACC) rsp_payload_outputs_0 <= {24'b0, acc_out};
               else                rsp_payload_outputs_0 <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
module tb_cfu_cmd_sequencer;

  localparam int unsigned MUL_LAT  = 4;
  localparam int unsigned VLEN_MAX = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic [4:0]  reg_op0_sel, reg_op1_sel, reg_wb_sel;
  logic        reg_load;
  logic [1:0]  bus_sel;
  logic [1:0]  alu_mode;
  logic        alu_op1_sel;
  logic [7:0]  alu_imm;
  logic [31:0] vtype;
  logic [5:0]  vlen;
  logic [2:0]  vlmul;
  logic [7:0]  acc_out;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic [31:0] vtype_m;
  logic [5:0]  vlen_m;

  always #5 clk = ~clk;

  cfu_cmd_sequencer #(.MUL_LAT(MUL_LAT), .VLEN_MAX(VLEN_MAX)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .reg_op0_sel(reg_op0_sel), .reg_op1_sel(reg_op1_sel),
    .reg_wb_sel(reg_wb_sel), .reg_load(reg_load),
    .bus_sel(bus_sel), .alu_mode(alu_mode), .alu_op1_sel(alu_op1_sel),
    .alu_imm(alu_imm), .vtype(vtype), .vlen(vlen), .vlmul(vlmul),
    .acc_out(acc_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0,
                         input logic [31:0] in1, input logic [31:0] exp_pl,
                         input int exp_lat, input int stall, input bit noise,
                         output int n_bus, output logic [1:0] bus_v,
                         output int n_load, output logic [4:0] wb_ld);
    int unsigned k;
    bit got;
    logic [31:0] exp_sb;
    n_bus = 0; bus_v = '0; n_load = 0; wb_ld = '0; got = 0; k = 0;
    @(negedge clk);
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    cmd_valid               = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    sb.push_back(exp_pl);
    @(negedge clk);
    if (noise) begin
      cmd_payload_function_id = 10'h000;
      cmd_payload_inputs_0    = 32'hDEAD_BEEF;
      cmd_payload_inputs_1    = 32'd7;
    end else begin
      cmd_valid = 1'b0;
    end
    for (k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (bus_sel != 2'b00) begin n_bus++; bus_v = bus_sel; end
      if (reg_load) begin n_load++; wb_ld = reg_wb_sel; end
      check("cmd_ready_busy", cmd_ready, 1'b0);
      @(negedge clk);
    end
    check("rsp_latency", (got ? int'(k) : -1), exp_lat);
    if (!got) begin
      sb.delete();
      cmd_valid = 1'b0;
      return;
    end
    check("resp_bus_sel", bus_sel, 2'b00);
    check("resp_reg_load", reg_load, 1'b0);
    for (int unsigned s = 0; s < int'(stall); s++) begin
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_payload", rsp_payload_outputs_0, exp_pl);
      check("stall_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("hs_rsp_valid", rsp_valid, 1'b1);
    exp_sb = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    check("rsp_payload", rsp_payload_outputs_0, exp_sb);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] csr_in0 [6];
    logic [31:0] csr_in1 [6];
    logic [31:0] exp_v;
    int          n_bus, n_load;
    logic [1:0]  bus_v;
    logic [4:0]  wb_ld;

    csr_in0 = '{32'h0000_0003, 32'h0000_0011, 32'h0000_02A5,
                32'h0000_0007, 32'h0000_0000, 32'h8000_0006};
    csr_in1 = '{32'd40, 32'd5, 32'd32, 32'd33, 32'd0, 32'hFFFF_FFFF};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    rsp_ready = 1'b0;
    acc_out = 8'h00;
    vtype_m = '0;
    vlen_m = '0;

    #1 reset = 1'b0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_payload", rsp_payload_outputs_0, 32'h0);
    check("rst_vtype", vtype, 32'h0);
    check("rst_vlen", vlen, 6'h0);
    check("rst_bus_sel", bus_sel, 2'b00);
    check("rst_reg_load", reg_load, 1'b0);
    check("rst_wb_sel", reg_wb_sel, 5'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1'b1);

    for (int unsigned i = 0; i < 6; i++) begin
      exp_v   = (csr_in1[i] > 32'(VLEN_MAX)) ? 32'(VLEN_MAX) : csr_in1[i];
      vtype_m = csr_in0[i];
      vlen_m  = exp_v[5:0];
      run_cmd(10'h000, csr_in0[i], csr_in1[i], exp_v, 1, 0, 1'b0,
              n_bus, bus_v, n_load, wb_ld);
      check("csr_vtype", vtype, vtype_m);
      check("csr_vlen", vlen, vlen_m);
      check("csr_vlmul", vlmul, vtype_m[2:0]);
      check("csr_no_load", n_load, 0);
      if (i == 0) begin
        check("csr0_vtype3", vtype, 32'h3);
        check("csr0_vlmul3", vlmul, 3'd3);
      end
    end

    run_cmd({7'b0000101, 3'd1}, 32'h0003_0201, 32'h0000_005A, 32'h0, 3, 0,
            1'b0, n_bus, bus_v, n_load, wb_ld);
    check("alu_bus_cycles", n_bus, 2);
    check("alu_bus_code", bus_v, 2'b01);
    check("alu_load_count", n_load, 1);
    check("alu_wb_at_load", wb_ld, 5'd3);
    check("alu_op1_sel", alu_op1_sel, 1'b1);
    check("alu_mode", alu_mode, 2'b01);
    check("alu_imm", alu_imm, 8'h5A);
    check("alu_op0_sel", reg_op0_sel, 5'd1);
    check("alu_op1_reg", reg_op1_sel, 5'd2);

    run_cmd(10'h002, 32'h0007_0605, 32'h0000_0011, 32'h0, MUL_LAT + 2, 5,
            1'b1, n_bus, bus_v, n_load, wb_ld);
    check("mul_bus_cycles", n_bus, MUL_LAT + 1);
    check("mul_bus_code", bus_v, 2'b10);
    check("mul_load_count", n_load, 1);
    check("mul_wb_at_load", wb_ld, 5'd7);
    check("mul_vtype_kept", vtype, vtype_m);
    check("mul_vlen_kept", vlen, vlen_m);

    acc_out = 8'hA5;
    run_cmd(10'h003, 32'h0009_0000, 32'h0, 32'h0000_00A5, 3, 0, 1'b0,
            n_bus, bus_v, n_load, wb_ld);
    check("acc_bus_cycles", n_bus, 2);
    check("acc_bus_code", bus_v, 2'b11);
    check("acc_no_load", n_load, 0);

    run_cmd(10'h007, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1, 0, 1'b0,
            n_bus, bus_v, n_load, wb_ld);
    check("ill7_bus", n_bus, 0);
    check("ill7_vtype", vtype, vtype_m);
    check("ill7_vlen", vlen, vlen_m);
    check("ill7_wb_sel", reg_wb_sel, 5'd9);
    run_cmd(10'h3FC, 32'h1234_5678, 32'd1, 32'hFFFF_FFFF, 1, 2, 1'b0,
            n_bus, bus_v, n_load, wb_ld);
    check("ill4_vtype", vtype, vtype_m);
    check("ill4_load", n_load, 0);

    @(negedge clk);
    cmd_payload_function_id = 10'h002;
    cmd_payload_inputs_0    = 32'h0001_0101;
    cmd_valid               = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_exec_bus", bus_sel, 2'b10);
    check("mid_exec_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_bus_sel", bus_sel, 2'b00);
    check("arst_reg_load", reg_load, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_payload", rsp_payload_outputs_0, 32'h0);
    check("arst_vtype", vtype, 32'h0);
    check("arst_op0_sel", reg_op0_sel, 5'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_rel_cmd_ready", cmd_ready, 1'b1);
    vtype_m = '0;
    vlen_m  = '0;

    run_cmd(10'h000, 32'h0000_0002, 32'd12, 32'd12, 1, 0, 1'b0,
            n_bus, bus_v, n_load, wb_ld);
    check("post_rst_vlmul", vlmul, 3'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
